demux_l2: RTL
=============

# demux_l2

Receive-side 1:2 byte demultiplexer for the PHY lane path. It takes the single interleaved byte stream produced by the transmit-side 2:1 lane multiplexer at clk_4f and splits it back into lane 00 and lane 11. It locks its lane phase on the first valid byte after reset. Each lane output then stays stable for two clk_4f cycles so half-rate consumers can sample it.

## Interface
- WIDTH, 8, data width of the serialized stream and of each lane.
- clk_4f  input  1  stream clock; all state changes on its rising edge.
- reset_L  input  1  asynchronous, active-low reset.
- data_000  input  WIDTH  interleaved stream byte; slot parity alternates lane 00 / lane 11.
- valid_000  input  1  data_000 carries a valid byte this cycle.
- data_00  output  WIDTH  lane 00 byte, registered.
- valid_00  output  1  lane 00 slot of the current pair was valid.
- data_11  output  WIDTH  lane 11 byte, registered.
- valid_11  output  1  lane 11 slot of the current pair was valid.
- pair_valid  output  1  one-cycle pulse: both slots of the just-completed pair were valid.
- locked  output  1  lane phase is established.

## Operation
- Internal state: a 1-bit state (SEARCH/LOCKED), a 1-bit slot selector sel (0 = lane 00 slot, 1 = lane 11 slot), and a 1-bit flag first_ok that records whether the lane 00 slot of the current pair was valid.
- SEARCH (reset state):
  - sel is held at 0.
  - valid_000=0: all outputs are held at their reset values.
  - valid_000=1: data_00<=data_000, valid_00<=1, first_ok<=1, sel<=1, locked<=1, state<=LOCKED.
- LOCKED, common rules:
  - sel toggles every cycle unconditionally, whether or not the input is valid, matching the free-running transmit selector.
  - Only reset leaves LOCKED.
- LOCKED, sel=0 (lane 00 slot):
  - valid_00<=valid_000 and first_ok<=valid_000.
  - If valid_000=1, data_00<=data_000; otherwise data_00 holds its previous value.
  - Lane 11 outputs are unchanged.
- LOCKED, sel=1 (lane 11 slot):
  - valid_11<=valid_000.
  - If valid_000=1, data_11<=data_000; otherwise data_11 holds.
  - Lane 00 outputs are unchanged.
  - pair_valid<=first_ok & valid_000.
- pair_valid is 0 in every other cycle.
- Invalid slots never overwrite lane data. Only the lane's valid flag drops.
- No arithmetic. Widths pass through unchanged.

## Timing
- Reset (asynchronous, immediate on reset_L=0):
  - data_00=0, data_11=0, valid_00=0, valid_11=0, pair_valid=0, locked=0.
  - sel=0, first_ok=0, state=SEARCH.
- Reset release: the first rising edge of clk_4f with reset_L=1 evaluates SEARCH.
- Latency: one clk_4f cycle from a byte on data_000 to its appearance on the lane output.
- Lane hold: each lane output and its valid update once every two cycles, so each value is stable for exactly two clk_4f cycles in LOCKED.
- pair_valid: asserts in the cycle after the lane 11 byte is sampled, the same cycle data_11 updates, with data_00 still showing the pair's lane 00 byte.
- Reset asserted mid-pair: the partial pair is discarded. The block returns to SEARCH, and the next valid byte becomes lane 00.
- Stream gaps while LOCKED do not realign the phase. A byte arriving in an odd slot goes to lane 11 even after a long idle.
- Back-to-back valid input at full rate: one pair_valid pulse every two cycles.

## Test plan
- Reset behaviour:
  - Stimulus: assert reset_L=0 asynchronously between clock edges while LOCKED.
  - Required: all outputs go to 0 immediately, and locked=0.
- Lock and full-rate split:
  - Stimulus: after reset, valid_000=0 for 3 cycles, then bytes 0xA1, 0xB1, 0xA2, 0xB2 with valid=1.
  - Required: data_00=0xA1 and locked=1 one cycle after 0xA1 is sampled.
  - Required: data_11=0xB1 with pair_valid=1, then data_00=0xA2, then data_11=0xB2 with pair_valid=1.
- Invalid lane 00 slot:
  - Stimulus: while locked, send lane 00 slot with valid=0 (data 0xFF), then lane 11 slot 0x5C with valid=1.
  - Required: data_00 holds its prior value and valid_00=0.
  - Required: data_11=0x5C, valid_11=1, pair_valid=0.
- Idle gap keeps phase:
  - Stimulus: while locked, 5 idle cycles (odd count), then byte 0x33 with valid=1.
  - Required: 0x33 appears on data_11, not data_00.
- Reset mid-pair:
  - Stimulus: capture lane 00 byte 0x10, pulse reset_L low for one cycle, then send 0x20 then 0x21.
  - Required: 0x20 appears on data_00, 0x21 on data_11, and no pair_valid involving 0x10.
- Loopback:
  - Stimulus: transmit-side 2:1 multiplexer driven with lane 00 = 0x01..0x08 and lane 11 = 0x81..0x88, output fed into this block.
  - Required: once locked, the recovered lane streams equal the sent sequences.

Source files
------------

// File: rtl/demux_l2.sv
// demux_l2: receive-side 1:2 lane demultiplexer.
// Locks lane phase on the first valid byte, then splits slots by parity.
module demux_l2 #(
  parameter int WIDTH = 8
) (
  input  logic             clk_4f,
  input  logic             reset_L,
  input  logic [WIDTH-1:0] data_000,
  input  logic             valid_000,
  output logic [WIDTH-1:0] data_00,
  output logic             valid_00,
  output logic [WIDTH-1:0] data_11,
  output logic             valid_11,
  output logic             pair_valid,
  output logic             locked
);

  typedef enum logic {SEARCH, LOCKED} state_t;

  state_t           r_state, w_state;
  logic             r_sel, w_sel;
  logic             r_first_ok, w_first_ok;
  logic [WIDTH-1:0] r_d00, w_d00;
  logic [WIDTH-1:0] r_d11, w_d11;
  logic             r_v00, w_v00;
  logic             r_v11, w_v11;
  logic             r_pv, w_pv;
  logic             r_locked, w_locked;

  always_ff @(posedge clk_4f or negedge reset_L) begin
    if (!reset_L) begin
      r_state    <= SEARCH;
      r_sel      <= 1'b0;
      r_first_ok <= 1'b0;
      r_d00      <= '0;
      r_d11      <= '0;
      r_v00      <= 1'b0;
      r_v11      <= 1'b0;
      r_pv       <= 1'b0;
      r_locked   <= 1'b0;
    end else begin
      r_state    <= w_state;
      r_sel      <= w_sel;
      r_first_ok <= w_first_ok;
      r_d00      <= w_d00;
      r_d11      <= w_d11;
      r_v00      <= w_v00;
      r_v11      <= w_v11;
      r_pv       <= w_pv;
      r_locked   <= w_locked;
    end
  end

  always_comb begin
    w_state    = r_state;
    w_sel      = r_sel;
    w_first_ok = r_first_ok;
    w_d00      = r_d00;
    w_d11      = r_d11;
    w_v00      = r_v00;
    w_v11      = r_v11;
    w_pv       = 1'b0;
    w_locked   = r_locked;
    unique case (r_state)
      SEARCH: begin
        w_sel = 1'b0;
        if (valid_000) begin
          w_d00      = data_000;
          w_v00      = 1'b1;
          w_first_ok = 1'b1;
          w_sel      = 1'b1;
          w_locked   = 1'b1;
          w_state    = LOCKED;
        end
      end
      LOCKED: begin
        // selector free-runs so idle gaps never shift the phase
        w_sel = ~r_sel;
        if (!r_sel) begin
          w_v00      = valid_000;
          w_first_ok = valid_000;
          if (valid_000) w_d00 = data_000;
        end else begin
          w_v11 = valid_000;
          w_pv  = r_first_ok & valid_000;
          if (valid_000) w_d11 = data_000;
        end
      end
      default: w_state = SEARCH;
    endcase
  end

  assign data_00    = r_d00;
  assign valid_00   = r_v00;
  assign data_11    = r_d11;
  assign valid_11   = r_v11;
  assign pair_valid = r_pv;
  assign locked     = r_locked;

endmodule
